// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam int   HUND_PER_SEC = 100;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit register: increments on en, wraps MAX->0, synchronous clear.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output bcd_t q,
  output logic at_max,
  output logic carry
);

  assign at_max = (q == bcd_t'(MAX));
  assign carry  = en & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: start/stop/clear FSM gating a cascaded SS.hh BCD counter.
// Optional lap-hold display freeze is enabled with `define STOPWATCH_LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SEC_TENS_MAX = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic go_btn,
  input  logic clr_btn,
  input  logic lap_btn,
  output bcd_t hund,
  output bcd_t tenth,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output logic running,
  output logic rollover
);

  sw_state_t  state, state_next;
  logic       go_reg;
  logic       go_edge;
  logic       count_en;
  logic       clr_digits;
  logic [3:0] en;
  logic [3:0] carry;
  logic [3:0] unused_at_max;
  bcd_t       live [4];

  assign go_edge    = go_btn & ~go_reg;
  assign count_en   = (state == RUN) & tick;
  assign clr_digits = clr_btn & (state != RUN);
  assign running    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      go_reg   <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state    <= state_next;
      go_reg   <= go_btn;
      rollover <= carry[3];
    end
  end

  // Clear takes priority over a go edge whenever the FSM is not running.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!clr_btn && go_edge) state_next = RUN;
      RUN:     if (go_edge) state_next = PAUSE;
      PAUSE: begin
        if (clr_btn)      state_next = IDLE;
        else if (go_edge) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign en = {carry[2:0], count_en};

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    bcd_digit #(
      .MAX((gi == 3) ? SEC_TENS_MAX : int'(BCD_MAX))
    ) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[gi]),
      .clr   (clr_digits),
      .q     (live[gi]),
      .at_max(unused_at_max[gi]),
      .carry (carry[gi])
    );
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_reg;
  logic hold_reg;
  logic lap_edge;
  bcd_t shadow [4];

  assign lap_edge = lap_btn & ~lap_reg;

  // Shadow captures the live count on the edge that raises hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_reg  <= 1'b0;
      hold_reg <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      lap_reg <= lap_btn;
      if (clr_digits || state_next == IDLE) begin
        hold_reg <= 1'b0;
      end else if (lap_edge && state == RUN) begin
        hold_reg <= ~hold_reg;
        if (!hold_reg) begin
          for (int i = 0; i < 4; i++) shadow[i] <= live[i];
        end
      end
    end
  end

  assign hund     = hold_reg ? shadow[0] : live[0];
  assign tenth    = hold_reg ? shadow[1] : live[1];
  assign sec_ones = hold_reg ? shadow[2] : live[2];
  assign sec_tens = hold_reg ? shadow[3] : live[3];
`else
  logic unused_lap;
  assign unused_lap = lap_btn;

  assign hund     = live[0];
  assign tenth    = live[1];
  assign sec_ones = live[2];
  assign sec_tens = live[3];
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core (default and STOPWATCH_LAP_EN builds).
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       go_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic [3:0] hund, tenth, sec_ones, sec_tens;
  logic       running, rollover;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(.SEC_TENS_MAX(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .go_btn  (go_btn),
    .clr_btn (clr_btn),
    .lap_btn (lap_btn),
    .hund    (hund),
    .tenth   (tenth),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .running (running),
    .rollover(rollover)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge.
  task automatic cyc(input logic g, input logic c, input logic l, input logic t);
    @(negedge clk);
    go_btn  = g;
    clr_btn = c;
    lap_btn = l;
    tick    = t;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {sec_tens, sec_ones, tenth, hund};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s display got %h want %h", tag, obs, exp);
    end
    $display("check %-14s display=%h", tag, obs);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, obs, exp);
    end
    $display("check %-14s value=%b", tag, obs);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_disp("reset_disp", 16'h0000);
    chk_bit("reset_run", running, 1'b0);
    chk_bit("reset_roll", rollover, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic count
    cyc(1, 0, 0, 0);
    chk_bit("go_running", running, 1'b1);
    cyc(0, 0, 0, 0);
    ticks(37);
    chk_disp("basic_37", 16'h0037);

    // Pause, then clear from PAUSE
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_bit("paused", running, 1'b0);
    cyc(0, 1, 0, 0);
    chk_disp("clr_from_pause", 16'h0000);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    ticks(5);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    ticks(3);
    chk_disp("pause_hold", 16'h0005);
    chk_bit("pause_run", running, 1'b0);
    cyc(0, 1, 0, 0);
    chk_disp("clear", 16'h0000);
    chk_bit("clear_run", running, 1'b0);
    cyc(0, 0, 0, 0);

    // Go and tick together from IDLE: tick not counted
    cyc(1, 0, 0, 1);
    chk_disp("go_tick_idle", 16'h0000);
    chk_bit("go_tick_run", running, 1'b1);
    cyc(0, 0, 0, 0);
    ticks(2);
    cyc(0, 1, 0, 0);
    chk_disp("clr_in_run", 16'h0002);
    chk_bit("clr_in_run_st", running, 1'b1);
    cyc(0, 0, 0, 1);
    chk_disp("after_clr_run", 16'h0003);

    // Go and tick together in RUN: tick counted, then PAUSE
    cyc(1, 0, 0, 1);
    chk_disp("go_tick_run", 16'h0004);
    chk_bit("go_tick_pause", running, 1'b0);
    cyc(0, 0, 0, 0);

    // Go and clear together in PAUSE: clear wins
    cyc(1, 1, 0, 0);
    chk_disp("go_clr_pause", 16'h0000);
    chk_bit("go_clr_state", running, 1'b0);
    cyc(0, 0, 0, 0);

    // Rollover and cascaded carries
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    ticks(100);
    chk_disp("one_sec", 16'h0100);
    ticks(899);
    chk_disp("nine_99", 16'h0999);
    ticks(1);
    chk_disp("ten_sec", 16'h1000);
    ticks(4999);
    chk_disp("max_count", 16'h5999);
    chk_bit("pre_roll", rollover, 1'b0);
    ticks(1);
    chk_disp("rolled", 16'h0000);
    chk_bit("roll_pulse", rollover, 1'b1);
    chk_bit("roll_running", running, 1'b1);
    cyc(0, 0, 0, 0);
    chk_bit("roll_once", rollover, 1'b0);

    // Asynchronous reset mid-count
    ticks(1234);
    chk_disp("pre_areset", 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk_disp("areset_disp", 16'h0000);
    chk_bit("areset_run", running, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lap hold (no effect when the feature is compiled out)
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    ticks(150);
    chk_disp("lap_pre", 16'h0150);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    ticks(20);
`ifdef STOPWATCH_LAP_EN
    chk_disp("lap_held", 16'h0150);
`else
    chk_disp("lap_ignored", 16'h0170);
`endif
    cyc(0, 0, 1, 0);
    chk_disp("lap_release", 16'h0170);
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Sequential timekeeping core of the stopwatch. It consumes a one-cycle 100 Hz `tick` from the upstream prescaler and keeps four cascaded BCD digit registers, SS.hh, counting 00.00–59.99. Each digit uses increment-and-wrap-at-9 logic, and the carry into the next digit is that digit's "at 9" detect ANDed with its enable. A start/stop/clear FSM gates counting, and the registered digits feed the display mux downstream.

## Interface
Parameters:
- `SEC_TENS_MAX`, default 5: terminal value of the seconds-tens digit.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle pulse every 10 ms.
- `go_btn`  in  1  start/stop request. Synchronized and debounced upstream, so it arrives as a level.
- `clr_btn`  in  1  clear request, level.
- `lap_btn`  in  1  lap request, level. Used only when `STOPWATCH_LAP_EN` is defined.
- `hund`  out  4  hundredths digit, BCD.
- `tenth`  out  4  tenths digit, BCD.
- `sec_ones`  out  4  seconds-ones digit, BCD.
- `sec_tens`  out  4  seconds-tens digit, BCD.
- `running`  out  1  high while in state RUN.
- `rollover`  out  1  one-cycle pulse when the count wraps from 59.99 to 00.00.

## Operation
- **Edge detect.** `go_btn` and `lap_btn` are each registered once. A press is the rising edge: current value 1, registered value 0. `clr_btn` acts on its level.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE → RUN on a go edge.
  - RUN → PAUSE on a go edge.
  - PAUSE → RUN on a go edge.
  - PAUSE → IDLE when `clr_btn`=1. All digits go to 0.
  - IDLE with `clr_btn`=1: stays IDLE, digits held at 0.
  - RUN ignores `clr_btn`.
  - PAUSE with a go edge and `clr_btn` in the same cycle: the clear wins and the state goes to IDLE.
- **Counting.**
  - Enabled only when state==RUN and `tick`=1.
  - `hund` increments and wraps 9→0.
  - Carry into a digit = the lower digit at its terminal value AND that lower digit's enable.
  - `tenth` and `sec_ones` wrap 9→0.
  - `sec_tens` wraps `SEC_TENS_MAX`→0.
- **Rollover.**
  - Occurs when all four digits are at their terminal values and the count is enabled.
  - All digits become 0 and `rollover` pulses for one cycle.
  - State stays RUN.
- **Illegal BCD values** (≥10) cannot occur from reset. No recovery logic is required.

## Timing
- **Reset values:**
  - State: IDLE.
  - Digits: all 0.
  - `running`=0, `rollover`=0.
  - Edge-detect flops: 0.
- **Outputs** are all registered; none is combinational from the inputs.
- **Go edge to `running`:**
  - Edge sampled in cycle n, so `running`=1 from cycle n+1.
  - A `tick` in cycle n is not counted, because the state is not yet RUN.
- **Tick to digit update:** a `tick` in a RUN cycle updates the digits at the end of that cycle, so the new value is visible the next cycle.
- **Stopping:** a go edge and a `tick` in the same RUN cycle count that tick, then move to PAUSE.
- **`rollover`** is high in the same cycle the digits first read 00.00.
- **Async reset mid-count** returns everything to the reset values immediately.

## Configuration
- **`STOPWATCH_LAP_EN` defined:** adds a lap-hold flag and four shadow digit registers.
  - A lap edge in RUN toggles the hold flag.
  - While hold=1, the outputs show the shadow digits, which were captured on the lap edge. Counting continues internally.
  - Hold clears on a lap edge, on a clear, on the transition to IDLE, or on reset.
  - In PAUSE and IDLE, lap edges are ignored.
- **Not defined:** `lap_btn` is present but unused, and the outputs are always the live digits.

## Structure
- **Package `stopwatch_pkg`:**
  - FSM enum `sw_state_t` {IDLE, RUN, PAUSE}.
  - `typedef logic [3:0] bcd_t`.
  - Constants `BCD_MAX=4'd9` and `HUND_PER_SEC=100`.
- **Sub-module `bcd_digit`:**
  - Parameter `MAX`.
  - Ports: `clk`, `rst_n`, `en`, `clr`, and output `q` (bcd_t).
  - Output `at_max` (combinational) and output `carry = en & at_max`.
  - Instantiated four times as a chain.

## Test plan
- **Basic count:** reset, go edge, 37 ticks → `running`=1, digits read 00.37.
- **Pause and clear:** go edge, 5 ticks, go edge, 3 ticks → reads 00.05 and `running`=0. Then `clr_btn`=1 for one cycle → 00.00 and state IDLE. `clr_btn` asserted during RUN → no effect.
- **Rollover:** run to 59.99, then 1 tick → 00.00, `rollover` high for exactly one cycle, `running` still 1.
- **Simultaneous events:**
  - Go edge and tick in the same IDLE cycle → the tick is not counted, so the display stays 00.00.
  - Go edge and tick in the same RUN cycle → the tick is counted.
  - In PAUSE, go edge and `clr_btn` in the same cycle → IDLE at 00.00.
- **Async reset:** assert `rst_n` low at 12.34 between clock edges → outputs read 00.00 before the next edge.
- **`STOPWATCH_LAP_EN`:** run to 01.50, lap edge, 20 ticks → outputs still 01.50. Lap edge again → outputs read 01.70.
